// File: rtl/tagger_pkg.sv
// Shared types for PatID tagging and throttling: counter widths and default AXI structs.
package tagger_pkg;

  localparam int CREDIT_W = 8;
  localparam int PERIOD_W = 16;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [PERIOD_W-1:0] period_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  user;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_dflt_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_dflt_t;

endpackage

// File: rtl/patid_credit_cnt.sv
// One partition's credit counter: period reload wins over a saturating 0..2 decrement.
module patid_credit_cnt
  import tagger_pkg::*;
#(
  parameter int WIDTH = $bits(credit_t)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] budget,
  input  logic [1:0]       dec,
  output logic [WIDTH-1:0] credit
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit <= '0;
    end else if (load) begin
      credit <= budget;
    end else if (32'(dec) >= 32'(credit)) begin
      credit <= '0;
    end else begin
      credit <= credit - WIDTH'(dec);
    end
  end

endmodule

// File: rtl/patid_throttle.sv
// Per-partition AXI AR/AW bandwidth regulator: gates valids on PatID credit, never on ready.
module patid_throttle
  import tagger_pkg::*;
#(
  parameter int  MAXPARTITION    = 16,
  parameter int  AXI_USER_ID_MSB = 7,
  parameter int  AXI_USER_ID_LSB = 0,
  parameter int  CREDIT_WIDTH    = $bits(credit_t),
  parameter int  PERIOD_WIDTH    = $bits(period_t),
  parameter type axi_req_t       = axi_req_dflt_t,
  parameter type axi_rsp_t       = axi_rsp_dflt_t
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  axi_req_t                                 slv_req_i,
  output axi_rsp_t                                 slv_rsp_o,
  output axi_req_t                                 mst_req_o,
  input  axi_rsp_t                                 mst_rsp_i,
  input  logic [PERIOD_WIDTH-1:0]                  cfg_period_i,
  input  logic [MAXPARTITION-1:0][CREDIT_WIDTH-1:0] cfg_budget_i,
  output logic [MAXPARTITION-1:0]                  throttled_o
);

  localparam int ID_W = AXI_USER_ID_MSB - AXI_USER_ID_LSB + 1;

  logic [ID_W-1:0]                         ar_p, aw_p;
  logic [PERIOD_WIDTH-1:0]                 period_cnt;
  logic [MAXPARTITION-1:0][CREDIT_WIDTH-1:0] credit;
  logic [MAXPARTITION-1:0][1:0]            dec;
  logic throttle_on, credit_load;
  logic ar_hold, aw_hold;
  logic ar_reg, aw_reg, ar_cred_nz, aw_cred_nz, ar_cred_one;
  logic tie, ar_fwd, aw_fwd;
  logic mst_ar_valid, mst_aw_valid, ar_dec, aw_dec;

  assign ar_p        = slv_req_i.ar.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB];
  assign aw_p        = slv_req_i.aw.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB];
  assign throttle_on = cfg_period_i != '0;
  assign credit_load = period_cnt == '0;

  // Out-of-range PatIDs match no partition and so stay unregulated.
  always_comb begin
    ar_reg      = 1'b0;
    aw_reg      = 1'b0;
    ar_cred_nz  = 1'b0;
    aw_cred_nz  = 1'b0;
    ar_cred_one = 1'b0;
    for (int p = 0; p < MAXPARTITION; p++) begin
      if (32'(ar_p) == 32'(p)) begin
        ar_reg      = throttle_on && (cfg_budget_i[p] != '0);
        ar_cred_nz  = credit[p] != '0;
        ar_cred_one = credit[p] == CREDIT_WIDTH'(1);
      end
      if (32'(aw_p) == 32'(p)) begin
        aw_reg     = throttle_on && (cfg_budget_i[p] != '0);
        aw_cred_nz = credit[p] != '0;
      end
    end
  end

  // Last credit contended by fresh AR and AW on one partition goes to AR.
  assign tie = slv_req_i.ar_valid && slv_req_i.aw_valid && (ar_p == aw_p) && ar_reg
               && !ar_hold && !aw_hold && ar_cred_one;

  assign ar_fwd       = !ar_reg || ar_cred_nz || ar_hold;
  assign aw_fwd       = (!aw_reg || aw_cred_nz || aw_hold) && !tie;
  assign mst_ar_valid = slv_req_i.ar_valid && ar_fwd && !rst_i;
  assign mst_aw_valid = slv_req_i.aw_valid && aw_fwd && !rst_i;
  assign ar_dec       = mst_ar_valid && mst_rsp_i.ar_ready && ar_reg;
  assign aw_dec       = mst_aw_valid && mst_rsp_i.aw_ready && aw_reg;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = mst_ar_valid;
    mst_req_o.aw_valid = mst_aw_valid;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_fwd && !rst_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_fwd && !rst_i;
  end

  always_comb begin
    for (int p = 0; p < MAXPARTITION; p++) begin
      dec[p] = {1'b0, ar_dec && (32'(ar_p) == 32'(p))}
             + {1'b0, aw_dec && (32'(aw_p) == 32'(p))};
    end
  end

  // A downstream valid without ready pins the transfer open until its handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_hold <= 1'b0;
      aw_hold <= 1'b0;
    end else begin
      if (mst_ar_valid) ar_hold <= !mst_rsp_i.ar_ready;
      if (mst_aw_valid) aw_hold <= !mst_rsp_i.aw_ready;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_cnt <= '0;
    end else if (!throttle_on || (period_cnt >= cfg_period_i - PERIOD_WIDTH'(1))) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < MAXPARTITION; g++) begin : g_part
    patid_credit_cnt #(.WIDTH(CREDIT_WIDTH)) u_credit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load   (credit_load),
      .budget (cfg_budget_i[g]),
      .dec    (dec[g]),
      .credit (credit[g])
    );
    assign throttled_o[g] = !rst_i && throttle_on && (cfg_budget_i[g] != '0) && (credit[g] == '0);
  end

endmodule

// File: tb/tb_patid_throttle.sv
// Directed scenarios plus randomized traffic against a per-partition credit reference model.
module tb_patid_throttle;
  import tagger_pkg::*;

  localparam int NP = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  axi_req_dflt_t         slv_req, mst_req;
  axi_rsp_dflt_t         slv_rsp, mst_rsp;
  logic [15:0]           cfg_period;
  logic [NP-1:0][7:0]    cfg_budget;
  logic [NP-1:0]         throttled;

  int            m_credit [NP];
  int            m_pcnt;
  bit            m_ar_hold, m_aw_hold;
  bit            e_mar_v, e_maw_v, e_sar_r, e_saw_r;
  logic [NP-1:0] e_thr;
  bit            cyc_ar_v, cyc_aw_v, cyc_ar_hs, cyc_aw_hs, cyc_sar_r;
  bit            ar_pend, aw_pend;
  int            n_assert = 0, n_fail = 0;
  int            hs_ar, hs_aw;

  patid_throttle #(
    .MAXPARTITION(NP), .AXI_USER_ID_MSB(7), .AXI_USER_ID_LSB(0),
    .CREDIT_WIDTH(8), .PERIOD_WIDTH(16),
    .axi_req_t(axi_req_dflt_t), .axi_rsp_t(axi_rsp_dflt_t)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp),
    .cfg_period_i(cfg_period), .cfg_budget_i(cfg_budget),
    .throttled_o(throttled)
  );

  always #5 clk = ~clk;

  function automatic bit regulated(int p);
    if (p < 0 || p >= NP) return 1'b0;
    return (cfg_period != 0) && (cfg_budget[p] != 0);
  endfunction

  // A regulated transfer may go if its partition has credit or it is already committed.
  task automatic model_eval();
    int arp = int'(slv_req.ar.user);
    int awp = int'(slv_req.aw.user);
    bit ar_ok = 1'b1, aw_ok = 1'b1;
    if (regulated(arp)) ar_ok = m_ar_hold || (m_credit[arp] > 0);
    if (regulated(awp)) aw_ok = m_aw_hold || (m_credit[awp] > 0);
    if (slv_req.ar_valid && slv_req.aw_valid && arp == awp && regulated(arp)
        && !m_ar_hold && !m_aw_hold && m_credit[arp] == 1) aw_ok = 1'b0;
    e_mar_v = !rst && slv_req.ar_valid && ar_ok;
    e_maw_v = !rst && slv_req.aw_valid && aw_ok;
    e_sar_r = !rst && mst_rsp.ar_ready && ar_ok;
    e_saw_r = !rst && mst_rsp.aw_ready && aw_ok;
    for (int p = 0; p < NP; p++) e_thr[p] = !rst && regulated(p) && (m_credit[p] == 0);
  endtask

  task automatic model_advance();
    int arp = int'(slv_req.ar.user);
    int awp = int'(slv_req.aw.user);
    bit ar_hs = e_mar_v && mst_rsp.ar_ready;
    bit aw_hs = e_maw_v && mst_rsp.aw_ready;
    if (rst) begin
      for (int p = 0; p < NP; p++) m_credit[p] = 0;
      m_pcnt = 0; m_ar_hold = 0; m_aw_hold = 0;
      return;
    end
    if (m_pcnt == 0) begin
      for (int p = 0; p < NP; p++) m_credit[p] = int'(cfg_budget[p]);
    end else begin
      if (ar_hs && regulated(arp) && m_credit[arp] > 0) m_credit[arp] -= 1;
      if (aw_hs && regulated(awp) && m_credit[awp] > 0) m_credit[awp] -= 1;
    end
    if (e_mar_v) m_ar_hold = !mst_rsp.ar_ready;
    if (e_maw_v) m_aw_hold = !mst_rsp.aw_ready;
    if (cfg_period == 0 || m_pcnt >= int'(cfg_period) - 1) m_pcnt = 0;
    else m_pcnt += 1;
  endtask

  task automatic expect_eq(string tag, int got, int want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic check_outputs();
    axi_req_dflt_t ereq;
    axi_rsp_dflt_t ersp;
    ereq = slv_req; ereq.ar_valid = e_mar_v; ereq.aw_valid = e_maw_v;
    ersp = mst_rsp; ersp.ar_ready = e_sar_r; ersp.aw_ready = e_saw_r;
    n_assert++;
    assert (mst_req === ereq) else begin
      n_fail++;
      $error("FAIL mst_req: got %h, want %h", mst_req, ereq);
    end
    n_assert++;
    assert (slv_rsp === ersp) else begin
      n_fail++;
      $error("FAIL slv_rsp: got %h, want %h", slv_rsp, ersp);
    end
    n_assert++;
    assert (throttled === e_thr) else begin
      n_fail++;
      $error("FAIL throttled: got %h, want %h", throttled, e_thr);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    check_outputs();
    cyc_ar_v  = mst_req.ar_valid;
    cyc_aw_v  = mst_req.aw_valid;
    cyc_sar_r = slv_rsp.ar_ready;
    cyc_ar_hs = mst_req.ar_valid && mst_rsp.ar_ready;
    cyc_aw_hs = mst_req.aw_valid && mst_rsp.aw_ready;
    hs_ar += int'(cyc_ar_hs);
    hs_aw += int'(cyc_aw_hs);
    ar_pend = !rst && slv_req.ar_valid && !e_sar_r;
    aw_pend = !rst && slv_req.aw_valid && !e_saw_r;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic align(int target);
    int guard = 0;
    while (m_pcnt != target && guard < 64) begin
      cycle();
      guard++;
    end
    expect_eq("align_timeout", guard < 64 ? 1 : 0, 1);
  endtask

  task automatic drive_ar(bit v, int p);
    slv_req.ar_valid = v;
    slv_req.ar.user  = 8'(p);
  endtask

  task automatic drive_aw(bit v, int p);
    slv_req.aw_valid = v;
    slv_req.aw.user  = 8'(p);
  endtask

  function automatic int pick_p();
    case ($urandom_range(0, 7))
      6:       return 17;
      7:       return 200;
      default: return int'($urandom_range(0, 5));
    endcase
  endfunction

  initial begin
    int waits, guard, vcnt;
    slv_req = '0; mst_rsp = '0; cfg_budget = '0;
    cfg_period = 16'd10; cfg_budget[3] = 8'd2;
    m_pcnt = 0; m_ar_hold = 0; m_aw_hold = 0;
    for (int p = 0; p < NP; p++) m_credit[p] = 0;
    hs_ar = 0; hs_aw = 0;
    mst_rsp.ar_ready = 1'b1; mst_rsp.aw_ready = 1'b1;
    rst = 1'b1;
    drive_ar(1, 3); drive_aw(1, 0);
    @(posedge clk); #1;
    cycle(); cycle();

    // Budget 2 per 10-cycle period on partition 3, continuous AR traffic.
    rst = 1'b0; drive_aw(0, 0); hs_ar = 0;
    cycle();
    expect_eq("post_rst_stall", int'(cyc_ar_v), 0);
    repeat (4) cycle();
    expect_eq("p3_throttled", int'(throttled[3]), 1);
    repeat (6) cycle();
    expect_eq("p3_hs_per_period", hs_ar, 2);
    cycle();
    expect_eq("p3_after_reload", int'(cyc_ar_hs), 1);

    // Zero budget is unregulated.
    drive_ar(0, 0); drive_aw(1, 5); hs_aw = 0;
    repeat (20) cycle();
    expect_eq("p5_unreg_hs", hs_aw, 20);
    expect_eq("p5_not_throttled", int'(throttled[5]), 0);

    // Same-cycle AR/AW contend for the last credit.
    drive_aw(0, 0); cfg_budget[1] = 8'd1;
    align(0); align(1);
    drive_ar(1, 1); drive_aw(1, 1);
    cycle();
    expect_eq("tie_ar_fwd", int'(cyc_ar_hs), 1);
    expect_eq("tie_aw_blocked", int'(cyc_aw_v), 0);
    drive_ar(0, 0);
    waits = 0; guard = 0;
    do begin
      cycle();
      if (!cyc_aw_hs) waits++;
      guard++;
    end while (!cyc_aw_hs && guard < 40);
    expect_eq("tie_aw_wait", waits, 9);

    // Held AW with a late AR on one credit; both complete together and saturate.
    drive_aw(0, 0); cfg_budget[2] = 8'd1;
    align(0); align(1);
    mst_rsp.ar_ready = 1'b0; mst_rsp.aw_ready = 1'b0;
    drive_aw(1, 2);
    cycle(); vcnt = int'(cyc_aw_v);
    drive_ar(1, 2);
    cycle(); vcnt += int'(cyc_aw_v);
    cycle(); vcnt += int'(cyc_aw_v);
    expect_eq("held_aw_valid", vcnt, 3);
    mst_rsp.ar_ready = 1'b1; mst_rsp.aw_ready = 1'b1;
    cycle();
    expect_eq("held_aw_done", int'(cyc_aw_hs), 1);
    drive_aw(0, 0);
    cycle();
    expect_eq("p2_ar_stall", int'(cyc_ar_v), 0);
    expect_eq("p2_throttled", int'(throttled[2]), 1);

    // Handshake at counter 0 is overridden by the reload.
    drive_ar(0, 0); cfg_budget[4] = 8'd4;
    align(1); align(0);
    drive_ar(1, 4); hs_ar = 0;
    repeat (10) cycle();
    expect_eq("reload_override_hs", hs_ar, 5);

    // Reset while an AR is held downstream.
    drive_ar(0, 0);
    align(2);
    mst_rsp.ar_ready = 1'b0;
    drive_ar(1, 3);
    cycle();
    expect_eq("pre_rst_held", int'(cyc_ar_v), 1);
    mst_rsp.ar_ready = 1'b1; rst = 1'b1;
    cycle();
    expect_eq("rst_ar_valid", int'(cyc_ar_v), 0);
    expect_eq("rst_ar_ready", int'(cyc_sar_r), 0);
    rst = 1'b0;
    cycle();
    expect_eq("rst_stall1", int'(cyc_ar_v), 0);
    cycle();
    expect_eq("rst_then_go", int'(cyc_ar_hs), 1);

    // Randomized traffic, config changes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 80 == 0) begin
        case ($urandom_range(0, 4))
          0: cfg_period = 16'd0;
          1: cfg_period = 16'd1;
          2: cfg_period = 16'd3;
          3: cfg_period = 16'd7;
          default: cfg_period = 16'd12;
        endcase
        for (int p = 0; p < 6; p++) cfg_budget[p] = 8'($urandom_range(0, 3));
      end
      if (!ar_pend) begin
        drive_ar(1'($urandom_range(0, 1)), pick_p());
        slv_req.ar.addr = $urandom;
      end
      if (!aw_pend) begin
        drive_aw(1'($urandom_range(0, 1)), pick_p());
        slv_req.aw.addr = $urandom;
      end
      slv_req.w.data   = $urandom;
      slv_req.w_valid  = 1'($urandom_range(0, 1));
      slv_req.r_ready  = 1'($urandom_range(0, 1));
      mst_rsp.r.data   = $urandom;
      mst_rsp.r_valid  = 1'($urandom_range(0, 1));
      mst_rsp.ar_ready = $urandom_range(0, 3) != 0;
      mst_rsp.aw_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
